vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//  Pixel-source stage directly downstream of the VGA sync generator. Consumes its sync, valid and
//  x/y position outputs and produces 24-bit RGB plus re-timed sync/DE for the output pins or DAC.
//  Four test patterns: colour bars, grid, gradient, and a bouncing box that moves once per frame.
//  Pattern selection is sampled only at frame start, so a pattern never changes mid-frame.
// PARAMETERS
//  H_ACTIVE   12'd1024  active pixels per line (box bounce limit)
//  V_ACTIVE   12'd768   active lines per frame (box bounce limit)
//  HS_POL     1'b0      active level of hsync in and out
//  VS_POL     1'b0      active level of vsync in and out
//  BAR_SHIFT  7         colour bar width = 2**BAR_SHIFT pixels
//  GRID_SHIFT 5         grid pitch = 2**GRID_SHIFT pixels/lines
//  BOX_SIZE   12'd64    bouncing box edge length, pixels
//  BOX_STEP   12'd4     box displacement per frame on each axis
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   asynchronous reset, active high
//  h_pulse_in   in   1   hsync from sync generator
//  v_pulse_in   in   1   vsync from sync generator
//  video_valid  in   1   active-video flag from sync generator
//  x_pos        in   12  current pixel column
//  y_pos        in   12  current pixel line
//  pattern_sel  in   2   0 bars, 1 grid, 2 gradient, 3 bouncing box
//  vga_hs       out  1   hsync delayed to match RGB
//  vga_vs       out  1   vsync delayed to match RGB
//  vga_de       out  1   data enable delayed to match RGB
//  vga_rgb      out  24  {R[7:0],G[7:0],B[7:0]}
// BEHAVIOUR
//  - Reset: vga_hs=~HS_POL, vga_vs=~VS_POL, vga_de=0, vga_rgb=0, active pattern=0,
//    box_x=box_y=0, dx=dy=+1 (moving right/down), vsync history reg=~VS_POL.
//  - Latency: exactly 2 clk from inputs to all outputs. Stage 1 registers hs/vs/de/x/y and the
//    pattern decode; stage 2 registers RGB. hs/vs/de go through the same 2 stages (no skew).
//  - vga_de=0 -> vga_rgb=24'h000000, regardless of pattern.
//  - Frame tick: one-cycle pulse when v_pulse_in==VS_POL and the previous sample !=VS_POL
//    (vsync assertion edge). A vsync held asserted gives one tick only.
//  - On frame tick: active pattern <= pattern_sel; if active pattern (before update) is 3, box steps.
//    pattern_sel changes between ticks are ignored.
//  - Pattern 0: idx=x_pos[BAR_SHIFT+2:BAR_SHIFT]; 0..7 = FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,
//    FF0000,0000FF,000000. Bars wrap beyond 8*2**BAR_SHIFT.
//  - Pattern 1: FFFFFF if x_pos[GRID_SHIFT-1:0]==0 or y_pos[GRID_SHIFT-1:0]==0, else 000000.
//  - Pattern 2: R=x_pos[9:2], G=y_pos[9:2], B=x_pos[9:2]^y_pos[9:2].
//  - Pattern 3: FFFFFF inside box (box_x<=x_pos<box_x+BOX_SIZE and same for y), else 000080.
//  - Box step, X axis (Y identical with V_ACTIVE/box_y/dy):
//    dx=+1 and box_x+BOX_SIZE+BOX_STEP>H_ACTIVE -> dx<=-1, box_x<=box_x-BOX_STEP;
//    dx=-1 and box_x<BOX_STEP -> dx<=+1, box_x<=box_x+BOX_STEP; else box_x<=box_x±BOX_STEP.
//    Box never leaves [0, H_ACTIVE-BOX_SIZE]; box arithmetic is 13-bit to avoid overflow.
//  - Box coordinates only change on a frame tick, never during active video.
//  - Reset mid-frame: all state returns to reset values at once; outputs inactive until
//    2 clk after rst deasserts; first frame tick after reset loads pattern_sel.
// TESTING
//  - Reset: assert rst mid-line -> vga_hs=1, vga_vs=1, vga_de=0, vga_rgb=0 same cycle; hold 2 clk after release.
//  - Latency: pulse video_valid 1 clk at x=5,y=0, pat 2 -> vga_de high exactly 2 clk later, rgb={8'h01,8'h00,8'h01}.
//  - Bars: pat 0, sweep x=0..1023 at y=100 -> FFFFFF for x 0..127, FFFF00 at 128, 000000 at 896..1023.
//  - Sel timing: change pattern_sel 0->1 mid-frame -> output stays bars until next vsync edge, then grid (x=32 -> FFFFFF, x=33,y=1 -> 0).
//  - Bounce: pat 3, run 240 frames -> box_x rises by 4/frame to 960, then 956, never >960 or <0; box_y turns at 704.
//  - Blanking: video_valid=0 with x/y in box -> vga_rgb=0; long vsync (3 lines) -> box moves once only.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source that sits behind the VGA sync generator. It has a fixed two-stage
// pipeline, so RGB, hsync, vsync and DE leave the block aligned.
module vga_pattern_gen #(
  parameter logic [11:0] H_ACTIVE   = 12'd1024,
  parameter logic [11:0] V_ACTIVE   = 12'd768,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned BAR_SHIFT  = 7,
  parameter int unsigned GRID_SHIFT = 5,
  parameter logic [11:0] BOX_SIZE   = 12'd64,
  parameter logic [11:0] BOX_STEP   = 12'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_pulse_in,
  input  logic        v_pulse_in,
  input  logic        video_valid,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [1:0]  pattern_sel,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [23:0] vga_rgb
);

  localparam logic [12:0] H_ACT13 = {1'b0, H_ACTIVE};
  localparam logic [12:0] V_ACT13 = {1'b0, V_ACTIVE};
  localparam logic [12:0] SIZE13  = {1'b0, BOX_SIZE};
  localparam logic [12:0] STEP13  = {1'b0, BOX_STEP};

  logic        r_vs_hist, r_dx_neg, r_dy_neg;
  logic [1:0]  r_pat, r_pat1;
  logic [12:0] r_box_x, r_box_y;
  logic        r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
  logic [11:0] r_x1, r_y1;
  logic [23:0] r_rgb;
  logic        w_tick, w_in_box;
  logic [13:0] w_step_x, w_step_y;
  logic [2:0]  w_bar_idx;
  logic [7:0]  w_gx, w_gy;
  logic [23:0] w_color;

  // Returns {direction, position}; direction 1 means moving towards zero.
  function automatic logic [13:0] step_axis(input logic [12:0] pos, input logic neg,
                                            input logic [12:0] lim);
    logic [12:0] p;
    logic        n;
    n = neg;
    if (!neg) begin
      if (pos + SIZE13 + STEP13 > lim) begin
        n = 1'b1;
        p = pos - STEP13;
      end else begin
        p = pos + STEP13;
      end
    end else if (pos < STEP13) begin
      n = 1'b0;
      p = pos + STEP13;
    end else begin
      p = pos - STEP13;
    end
    return {n, p};
  endfunction

  assign w_tick = (v_pulse_in == VS_POL) && (r_vs_hist != VS_POL);

  always_comb begin
    w_step_x = step_axis(r_box_x, r_dx_neg, H_ACT13);
    w_step_y = step_axis(r_box_y, r_dy_neg, V_ACT13);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_hist <= ~VS_POL;
      r_pat     <= 2'd0;
      r_box_x   <= '0;
      r_box_y   <= '0;
      r_dx_neg  <= 1'b0;
      r_dy_neg  <= 1'b0;
    end else begin
      r_vs_hist <= v_pulse_in;
      if (w_tick) begin
        r_pat <= pattern_sel;
        if (r_pat == 2'd3) begin
          {r_dx_neg, r_box_x} <= w_step_x;
          {r_dy_neg, r_box_y} <= w_step_y;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs1  <= ~HS_POL;
      r_vs1  <= ~VS_POL;
      r_de1  <= 1'b0;
      r_x1   <= '0;
      r_y1   <= '0;
      r_pat1 <= 2'd0;
      r_hs2  <= ~HS_POL;
      r_vs2  <= ~VS_POL;
      r_de2  <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_hs1  <= h_pulse_in;
      r_vs1  <= v_pulse_in;
      r_de1  <= video_valid;
      r_x1   <= x_pos;
      r_y1   <= y_pos;
      r_pat1 <= r_pat;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_de2  <= r_de1;
      r_rgb  <= r_de1 ? w_color : 24'h000000;
    end
  end

  always_comb begin
    w_bar_idx = r_x1[BAR_SHIFT+2:BAR_SHIFT];
    w_gx      = r_x1[9:2];
    w_gy      = r_y1[9:2];
    w_in_box  = ({1'b0, r_x1} >= r_box_x) && ({1'b0, r_x1} < r_box_x + SIZE13) &&
                ({1'b0, r_y1} >= r_box_y) && ({1'b0, r_y1} < r_box_y + SIZE13);
    w_color   = 24'h000000;
    unique case (r_pat1)
      2'd0: begin
        case (w_bar_idx)
          3'd0:    w_color = 24'hFFFFFF;
          3'd1:    w_color = 24'hFFFF00;
          3'd2:    w_color = 24'h00FFFF;
          3'd3:    w_color = 24'h00FF00;
          3'd4:    w_color = 24'hFF00FF;
          3'd5:    w_color = 24'hFF0000;
          3'd6:    w_color = 24'h0000FF;
          default: w_color = 24'h000000;
        endcase
      end
      2'd1: begin
        if (r_x1[GRID_SHIFT-1:0] == '0 || r_y1[GRID_SHIFT-1:0] == '0) w_color = 24'hFFFFFF;
      end
      2'd2: w_color = {w_gx, w_gy, w_gx ^ w_gy};
      2'd3: w_color = w_in_box ? 24'hFFFFFF : 24'h000080;
    endcase
  end

  assign vga_hs  = r_hs2;
  assign vga_vs  = r_vs2;
  assign vga_de  = r_de2;
  assign vga_rgb = r_rgb;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: the driver pushes model-predicted outputs per pixel clock,
// and the monitor pops and compares them two clocks later.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1, vv = 1'b0;
  logic [11:0] x = '0, y = '0;
  logic [1:0]  sel = 2'd0;
  logic        o_hs, o_vs, o_de;
  logic [23:0] o_rgb;

  vga_pattern_gen dut (
    .clk(clk), .rst(rst), .h_pulse_in(hs), .v_pulse_in(vs), .video_valid(vv),
    .x_pos(x), .y_pos(y), .pattern_sel(sel),
    .vga_hs(o_hs), .vga_vs(o_vs), .vga_de(o_de), .vga_rgb(o_rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    int          id;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          n_tests = 0, n_fail = 0, n_pushed = 0;
  bit          mon_en = 1'b0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference model state: active pattern, last vsync sample, box steps taken.
  int   m_pat = 0;
  logic m_vprev = 1'b1;
  int   m_steps = 0;

  // Box position is a triangle wave of the distance travelled.
  function automatic int tri_pos(int d, int lim);
    int p;
    p = d % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic logic [23:0] model_rgb(int pat, int px, int py, int steps);
    logic [7:0] r, g;
    int bx, by;
    case (pat)
      0: return bars[(px / 128) % 8];
      1: return (px % 32 == 0 || py % 32 == 0) ? 24'hFFFFFF : 24'h000000;
      2: begin
        r = 8'((px / 4) % 256);
        g = 8'((py / 4) % 256);
        return {r, g, r ^ g};
      end
      default: begin
        bx = tri_pos(4 * steps, 960);
        by = tri_pos(4 * steps, 704);
        return (px >= bx && px < bx + 64 && py >= by && py < by + 64) ? 24'hFFFFFF
                                                                     : 24'h000080;
      end
    endcase
  endfunction

  task automatic px(input logic h, input logic v, input logic val, input int xi, input int yi);
    exp_t e;
    @(negedge clk);
    hs = h; vs = v; vv = val; x = xi[11:0]; y = yi[11:0];
    e.hs  = h;
    e.vs  = v;
    e.de  = val;
    e.rgb = val ? model_rgb(m_pat, int'(x), int'(y), m_steps) : 24'h000000;
    e.id  = n_pushed;
    n_pushed++;
    q.push_back(e);
    if (v == 1'b0 && m_vprev == 1'b1) begin
      if (m_pat == 3) m_steps++;
      m_pat = int'(sel);
    end
    m_vprev = v;
  endtask

  task automatic frame_start(input int vlen);
    px(1'b1, 1'b1, 1'b0, 0, 0);
    repeat (vlen) px(1'b1, 1'b0, 1'b0, 0, 0);
    px(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [26:0] got, input logic [26:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && !rst) begin
      n_tests++;
      if (q.size() >= 2) begin
        me = q.pop_front();
        if ({o_hs, o_vs, o_de, o_rgb} !== {me.hs, me.vs, me.de, me.rgb}) begin
          n_fail++;
          $display("FAIL px%0d hs/vs/de/rgb: got %b%b%b %h, expected %b%b%b %h", me.id,
                   o_hs, o_vs, o_de, o_rgb, me.hs, me.vs, me.de, me.rgb);
        end
      end else if ({o_hs, o_vs, o_de, o_rgb} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
        n_fail++;
        $display("FAIL post-reset idle: got %b%b%b %h", o_hs, o_vs, o_de, o_rgb);
      end
    end
  end

  task automatic release_reset();
    hs = 1'b1; vs = 1'b1; vv = 1'b0; x = '0; y = '0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    int bx, by, xr;
    #12;
    chk("reset outputs", {o_hs, o_vs, o_de, o_rgb}, {1'b1, 1'b1, 1'b0, 24'h0});
    repeat (2) @(negedge clk);
    release_reset();

    // Latency with gradient: single valid pixel at (5,0).
    sel = 2'd2;
    frame_start(2);
    px(1'b1, 1'b1, 1'b0, 4, 0);
    px(1'b1, 1'b1, 1'b1, 5, 0);
    px(1'b1, 1'b1, 1'b0, 6, 0);
    repeat (30) px(1'($urandom), 1'b1, 1'b1, $urandom_range(0, 4095), $urandom_range(0, 4095));

    // Colour bars full-line sweep.
    sel = 2'd0;
    frame_start(2);
    for (int i = 0; i < 1024; i++) px(1'($urandom), 1'b1, 1'b1, i, 100);
    px(1'b1, 1'b1, 1'b0, 0, 0);

    // Selection change mid-frame is ignored until the next vsync edge.
    sel = 2'd1;
    repeat (20) px(1'b1, 1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 767));
    frame_start(3);
    px(1'b1, 1'b1, 1'b1, 32, 7);
    px(1'b1, 1'b1, 1'b1, 33, 1);
    px(1'b1, 1'b1, 1'b1, 33, 64);
    repeat (20) px(1'b1, 1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 767));

    // Bouncing box, including long vsync pulses and blanked in-box pixels.
    sel = 2'd3;
    frame_start(2);
    for (int f = 0; f < 250; f++) begin
      bx = tri_pos(4 * m_steps, 960);
      by = tri_pos(4 * m_steps, 704);
      sel = 2'($urandom);
      px(1'b1, 1'b1, 1'b1, bx, by);
      px(1'b1, 1'b1, 1'b1, bx - 1, by);
      px(1'b1, 1'b1, 1'b1, bx + 63, by + 63);
      px(1'b1, 1'b1, 1'b1, bx + 64, by);
      px(1'b1, 1'b1, 1'b1, bx, by - 1);
      px(1'b1, 1'b1, 1'b1, bx, by + 64);
      px(1'b1, 1'b1, 1'b0, bx + 10, by + 10);
      xr = $urandom_range(0, 1023);
      px(1'b1, 1'b1, 1'b1, xr, $urandom_range(0, 767));
      sel = 2'd3;
      frame_start((f % 50 == 7) ? 30 : 2);
    end

    // Asynchronous reset in the middle of an active line.
    repeat (4) px(1'b1, 1'b1, 1'b1, $urandom_range(0, 1023), 300);
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid-line reset hs", {26'h0, o_hs}, 27'h1);
    chk("mid-line reset vs", {26'h0, o_vs}, 27'h1);
    chk("mid-line reset de", {26'h0, o_de}, 27'h0);
    chk("mid-line reset rgb", {3'b0, o_rgb}, 27'h0);
    q.delete();
    m_pat = 0;
    m_vprev = 1'b1;
    m_steps = 0;
    repeat (2) @(negedge clk);
    release_reset();

    // After reset: first frame tick loads the selection, box restarts at the origin.
    sel = 2'd2;
    repeat (5) px(1'b1, 1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 767));
    frame_start(2);
    repeat (10) px(1'b1, 1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 767));
    sel = 2'd3;
    frame_start(2);
    px(1'b1, 1'b1, 1'b1, 0, 0);
    px(1'b1, 1'b1, 1'b1, 64, 0);
    px(1'b1, 1'b1, 1'b1, 63, 63);
    px(1'b1, 1'b1, 1'b1, 0, 64);
    repeat (2) px(1'b1, 1'b1, 1'b0, 0, 0);
    mon_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
